coprosit_result_queue: RTL

- Writeback stage of the Coprosit coprocessor, directly downstream of the posit ALU (compare/min/max) and the PRAU arithmetic unit.
- Arbitrates between the two result sources and buffers completed results in a DEPTH-entry FIFO.
- Presents buffered results in order on the host CPU's coprocessor result channel, using a valid/ready handshake.
- Generates the ALU output handshake pulse that clears the ALU's input registers.

---
 rtl/coprosit_result_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/coprosit_result_queue.sv
// Writeback queue for the Coprosit coprocessor: merges PRAU and ALU results
// into an in-order FIFO and presents them on the host result channel.
module coprosit_result_queue #(
  parameter int XLEN       = 32,
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,

  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [XLEN-1:0]          alu_data_i,
  input  logic [X_ID_WIDTH-1:0]    alu_id_i,
  input  logic [4:0]               alu_rd_i,
  output logic                     alu_output_hs_o,

  input  logic                     prau_valid_i,
  output logic                     prau_ready_o,
  input  logic [XLEN-1:0]          prau_data_i,
  input  logic [X_ID_WIDTH-1:0]    prau_id_i,
  input  logic [4:0]               prau_rd_i,

  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_data_o,
  output logic [X_ID_WIDTH-1:0]    result_id_o,
  output logic [4:0]               result_rd_o,
  output logic                     result_we_o,

  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + X_ID_WIDTH + 5;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid & ready are both 1.
  // Sources hold valid and payload until ready; ready never depends on the
  // same-cycle pop, so there is no full-queue pass-through.

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  rptr_q;
  logic [AW-1:0]  wptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;

  logic           full;
  logic           empty;
  logic           push_prau;
  logic           push_alu;
  logic           push;
  logic           pop;
  logic [EW-1:0]  push_entry;
  logic [EW-1:0]  head_entry;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // PRAU has fixed priority; the ALU is only offered a slot when PRAU is idle.
  assign prau_ready_o    = !full;
  assign alu_ready_o     = !full && !prau_valid_i;
  assign alu_output_hs_o = alu_valid_i && alu_ready_o;

  assign push_prau = prau_valid_i && prau_ready_o;
  assign push_alu  = alu_valid_i && alu_ready_o;
  assign push      = push_prau || push_alu;
  assign pop       = result_valid_o && result_ready_i;

  always_comb begin
    push_entry = {alu_data_i, alu_id_i, alu_rd_i};
    if (push_prau) begin
      push_entry = {prau_data_i, prau_id_i, prau_rd_i};
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage carries no reset: every read is gated by count_q.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push) begin
      mem_q[wptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_entry     = empty ? '0 : mem_q[rptr_q];
  assign result_valid_o = !empty;
  assign result_we_o    = !empty;
  assign result_data_o  = head_entry[EW-1 -: XLEN];
  assign result_id_o    = head_entry[5 +: X_ID_WIDTH];
  assign result_rd_o    = head_entry[4:0];
  assign occupancy_o    = count_q;

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= FULL_COUNT);
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    empty |-> !pop);
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    full |-> !push);
  a_one_push : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_prau && push_alu));

endmodule
